instr_fetch: RTL and testbench

Instruction fetch stage directly downstream of the program counter. Takes the current PC, requests one 32-bit instruction at a time from instruction memory with a request/grant/response handshake and pulses `pc_incr` back to the PC on every accepted request. Fetched instructions and their PCs go into a small FIFO that feeds decode through a valid/ready interface. A `flush` input discards buffered and in-flight instructions when the PC is redirected.

---
 rtl/instr_fetch.sv | 91 +++++++++
 tb/tb_instr_fetch.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage issuing one outstanding imem request at a time into a small decode FIFO.
// A flush empties the FIFO and, if a response is still in flight, marks it for discard.
module instr_fetch #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_incr,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              dec_valid,
  output logic [31:0]       dec_instr,
  output logic [ADDR_W-1:0] dec_pc,
  input  logic              dec_ready
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     wptr_q, rptr_q;
  logic              discard_q, discard_d;
  logic [ADDR_W-1:0] pend_pc_q;
  logic [31:0]       instr_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_q [DEPTH];
  logic              in_wait, push, pop, room;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      discard_q <= 1'b0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      pend_pc_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= '0;
        pc_mem_q[i]    <= '0;
      end
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      discard_q <= discard_d;
      if (pc_incr) pend_pc_q <= pc_in;
      if (push) begin
        instr_mem_q[wptr_q] <= imem_rdata;
        pc_mem_q[wptr_q]    <= pend_pc_q;
        wptr_q              <= wptr_q + PW'(1);
      end
      rptr_q <= flush ? wptr_q : pop ? rptr_q + PW'(1) : rptr_q;
    end
  end

  // Datapath next-state: flush overrides both push and pop
  always_comb begin
    in_wait   = state_q == WAIT;
    push      = in_wait && imem_rvalid && !discard_q && !flush;
    pop       = dec_valid && dec_ready && !flush;
    count_d   = flush ? '0 : count_q + CW'(push) - CW'(pop);
    room      = count_d < CW'(DEPTH);
    discard_d = (in_wait && flush && !imem_rvalid) ? 1'b1 :
                (in_wait && imem_rvalid) ? 1'b0 : discard_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = room ? REQ : IDLE;
      REQ:     state_d = pc_incr ? WAIT : REQ;
      WAIT:    state_d = imem_rvalid ? (room ? REQ : IDLE) : WAIT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req  = (state_q == REQ) && !flush;
    imem_addr = pc_in;
    pc_incr   = imem_req && imem_gnt;
    dec_valid = count_q != '0;
    dec_instr = instr_mem_q[rptr_q];
    dec_pc    = pc_mem_q[rptr_q];
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed scenarios plus randomized traffic checked against a queue-based fetch model.
module tb_instr_fetch;
  localparam int AW = 32;
  localparam int D  = 2;

  logic          clock = 0, reset = 0;
  logic [AW-1:0] pc_in = '0, imem_addr, dec_pc;
  logic          pc_incr, flush = 0, imem_req, imem_gnt = 0, imem_rvalid = 0;
  logic [31:0]   imem_rdata = '0, dec_instr;
  logic          dec_valid, dec_ready = 0;

  instr_fetch #(.ADDR_W(AW), .DEPTH(D)) dut (
    .clock(clock), .reset(reset), .pc_in(pc_in), .pc_incr(pc_incr), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .dec_valid(dec_valid),
    .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_ready(dec_ready)
  );

  always #5 clock = ~clock;

  typedef struct packed {logic [31:0] pc; logic [31:0] ins;} ent_t;

  // Model: a queue of fetched entries, one in-flight flag, a drop-next-response flag, a parked flag
  ent_t        q[$];
  bit          m_out, m_drop, m_idle, e_req, e_incr;
  logic [31:0] m_pend, pc, data_fix, redir, addr0;
  int          checks = 0, failures = 0;
  int          gnt_p, rv_p, rdy_p, fl_p, spur_p;
  bit          use_fix = 0, use_redir = 0, rv_force = 0, seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit roll(input int p);
    return int'($urandom_range(99, 0)) < p;
  endfunction

  task automatic knobs(input int g, input int r, input int d, input int f, input int s);
    gnt_p = g; rv_p = r; rdy_p = d; fl_p = f; spur_p = s;
  endtask

  task automatic do_reset;
    @(negedge clock);
    #2;
    reset = 1; flush = 0; imem_gnt = 0; imem_rvalid = 0; dec_ready = 0; pc_in = pc;
    q.delete(); m_out = 0; m_drop = 0; m_idle = 1;
    #1;
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_incr", 32'(pc_incr), 0);
    chk("rst_valid", 32'(dec_valid), 0);
    chk("rst_instr", dec_instr, 0);
    chk("rst_pc", dec_pc, 0);
    repeat (2) @(posedge clock);
  endtask

  task automatic drive;
    @(negedge clock);
    reset = 0;
    flush = roll(fl_p);
    if (flush) pc = use_redir ? redir : ($urandom & 32'hFFFF_FFFC);
    pc_in = pc;
    e_req = !m_idle && !m_out && !flush;
    imem_gnt = roll(gnt_p);
    imem_rvalid = m_out ? roll(rv_p) : (!(e_req && imem_gnt) && roll(spur_p));
    if (rv_force) imem_rvalid = 1;
    if (imem_rvalid) imem_gnt = 0;
    e_incr = e_req && imem_gnt;
    imem_rdata = use_fix ? data_fix : $urandom;
    dec_ready = roll(rdy_p);
    #1;
    chk("imem_req", 32'(imem_req), 32'(e_req));
    chk("pc_incr", 32'(pc_incr), 32'(e_incr));
    chk("imem_addr", imem_addr, pc);
    chk("dec_valid", 32'(dec_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("dec_pc", dec_pc, q[0].pc);
      chk("dec_instr", dec_instr, q[0].ins);
    end
  endtask

  task automatic adv;
    bit   rv, push, pop;
    ent_t e;
    @(posedge clock);
    rv   = m_out && imem_rvalid;
    push = rv && !m_drop && !flush;
    pop  = q.size() != 0 && dec_ready && !flush;
    if (flush) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        e.pc = m_pend; e.ins = imem_rdata;
        q.push_back(e);
      end
    end
    if (m_out && flush && !imem_rvalid) m_drop = 1;
    else if (rv) m_drop = 0;
    if (e_incr) begin
      m_out = 1; m_pend = pc; pc = pc + 4;
    end else if (rv) begin
      m_out = 0; m_idle = q.size() >= D;
    end else if (m_idle) m_idle = q.size() >= D;
  endtask

  task automatic cyc;
    drive;
    adv;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Best-case single fetch timing
    knobs(100, 100, 100, 0, 0); use_fix = 1; data_fix = 32'h13; pc = 0;
    do_reset;
    drive; chk("t1_c0_req", 32'(imem_req), 0); adv;
    drive; chk("t1_c1_incr", 32'(pc_incr), 1); adv;
    cyc;
    drive;
    chk("t1_c3_valid", 32'(dec_valid), 1);
    chk("t1_c3_pc", dec_pc, 0);
    chk("t1_c3_instr", dec_instr, 32'h13);
    adv;
    use_fix = 0;

    // Fill with decode stalled, park, then drain in order and resume
    knobs(100, 100, 0, 0, 0); pc = 0;
    do_reset;
    repeat (5) cyc;
    repeat (4) begin
      drive;
      chk("t2_park_req", 32'(imem_req), 0);
      chk("t2_park_incr", 32'(pc_incr), 0);
      chk("t2_full", 32'(dec_valid), 1);
      adv;
    end
    rdy_p = 100;
    drive; chk("t2_pop0", dec_pc, 0); adv;
    drive; chk("t2_pop1", dec_pc, 4); seen = pc_incr; adv;
    repeat (4) begin
      drive; if (pc_incr) seen = 1; adv;
    end
    chk("t2_resume", 32'(seen), 1);

    // Grant withheld: request held steady
    knobs(0, 0, 100, 0, 0); pc = 32'h40;
    do_reset;
    cyc;
    addr0 = 32'h40;
    repeat (5) begin
      drive;
      chk("t3_req", 32'(imem_req), 1);
      chk("t3_addr", imem_addr, addr0);
      chk("t3_incr", 32'(pc_incr), 0);
      adv;
    end

    // Flush while waiting; late response is discarded
    knobs(100, 0, 0, 0, 0); pc = 0;
    do_reset;
    cyc; cyc;
    fl_p = 100; use_redir = 1; redir = 32'h100;
    cyc;
    fl_p = 0;
    repeat (2) cyc;
    rv_p = 100; use_fix = 1; data_fix = 32'hDEADBEEF;
    drive; chk("t4_rsp_valid", 32'(dec_valid), 0); adv;
    rv_p = 0; use_fix = 0;
    drive;
    chk("t4_after_valid", 32'(dec_valid), 0);
    chk("t4_req", 32'(imem_req), 1);
    chk("t4_addr", imem_addr, 32'h100);
    adv;
    use_redir = 0;

    // Flush a full FIFO with decode ready in the same cycle
    knobs(100, 100, 0, 0, 0); pc = 0;
    do_reset;
    repeat (7) cyc;
    fl_p = 100; rdy_p = 100;
    drive; chk("t5_pre_valid", 32'(dec_valid), 1); adv;
    fl_p = 0; rdy_p = 0;
    drive; chk("t5_post_valid", 32'(dec_valid), 0); adv;

    // Reset during WAIT; stale response after release is ignored
    knobs(100, 0, 100, 0, 0); pc = 32'h200;
    do_reset;
    cyc; cyc; cyc;
    do_reset;
    gnt_p = 0; rv_force = 1;
    drive; chk("t6_c0_valid", 32'(dec_valid), 0); adv;
    rv_force = 0; gnt_p = 100;
    drive;
    chk("t6_c1_valid", 32'(dec_valid), 0);
    chk("t6_c1_req", 32'(imem_req), 1);
    chk("t6_c1_addr", imem_addr, pc);
    adv;

    // Randomized traffic with occasional async resets
    knobs(50, 40, 60, 4, 10);
    do_reset;
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) knobs($urandom_range(100, 10), $urandom_range(100, 10),
                              $urandom_range(100, 0), $urandom_range(8, 0), $urandom_range(20, 0));
      if ($urandom_range(599, 0) == 0) do_reset;
      cyc;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
